text_ram_writer: RTL
====================

# text_ram_writer

Processor-side writer for the character text RAM that the VGA text renderer reads. It captures byte stores from the processor data bus that fall inside the text window, buffers them in a small FIFO, and drains them into the RAM write port only while the display is blanked, so the renderer never sees a mid-line change. It sits between the processor (`MemWrite`/`DataAdr`/`WriteData`) and the write port of the updated-text RAM, beside the VGA block.

## Interface
- `BASE_ADDR`, 32'h0000_1000: first processor byte address of the text window.
- `TEXT_CHARS`, 4096: window size in characters; must be ≤ 2**`ADDR_W`.
- `ADDR_W`, 12: RAM address width.
- `DEPTH`, 8: FIFO entries, power of two.
- `CLEAR_CHAR`, 8'h20: fill byte used by the clear engine.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_write`  in  1  processor store strobe, one cycle per store.
- `data_adr`  in  32  processor store address.
- `write_data`  in  32  store data; only [7:0] is used.
- `blank`  in  1  high while the VGA output is outside the visible area.
- `clear_req`  in  1  one-cycle pulse requesting a full-RAM fill.
- `ram_addr`  out  `ADDR_W`  RAM write address (registered).
- `ram_data`  out  8  RAM write data (registered).
- `ram_wren`  out  1  RAM write enable (registered).
- `busy`  out  1  high when the FIFO is non-empty or the FSM is not IDLE.
- `overflow`  out  1  sticky: a store was dropped because the FIFO was full.
- `level`  out  $clog2(`DEPTH`)+1  current FIFO occupancy.

## Operation
- Window hit: `mem_write` && `data_adr` ≥ `BASE_ADDR` && `data_adr` < `BASE_ADDR`+`TEXT_CHARS`. Offset = `data_adr`−`BASE_ADDR`, truncated to `ADDR_W`. Misses are ignored.
- Push: on a hit, {offset, `write_data[7:0]`} is pushed. If the FIFO is full and no pop happens in the same cycle, the store is dropped and `overflow` is set. `overflow` clears only on reset.
- Full with a simultaneous pop: the push is accepted and `level` is unchanged.
- FSM states are IDLE, DRAIN and CLEAR.
  - IDLE → DRAIN when `blank` is high and `level`>0.
  - DRAIN pops one entry per cycle while `blank` is high and `level`>0. Each pop loads `ram_addr`/`ram_data` and pulses `ram_wren` for one cycle.
  - DRAIN → IDLE when `blank` falls or the FIFO is empty.
- Write order is FIFO order. Two stores to the same address both reach the RAM, and the last one wins.
- `clear_req` is sampled in IDLE only and moves the FSM to CLEAR. It is ignored in DRAIN and CLEAR.
- CLEAR writes `CLEAR_CHAR` to addresses 0..`TEXT_CHARS`−1 in ascending order, one per cycle while `blank` is high, and pauses while `blank` is low. After the last address it returns to IDLE.
- The FIFO keeps accepting stores during CLEAR. Those stores drain after the clear finishes, so they overwrite the fill.
- Reset mid-operation empties the FIFO, returns the FSM to IDLE and aborts any in-progress clear. No partial state survives.

## Timing
- Reset values: `ram_addr`=0, `ram_data`=0, `ram_wren`=0, `busy`=0, `overflow`=0, `level`=0, state IDLE.
- Store sampled at edge N → `level` increments after N. The earliest `ram_wren` is high after edge N+1, if `blank` was high at N+1.
- `blank` sampled low at edge M → no pop at M. A write already registered at M−1 still completes during cycle M.
- Peak drain throughput is 1 byte per clock. Sustained processor store rate of 1 per clock with `blank` low overflows after `DEPTH` stores.
- CLEAR of `TEXT_CHARS` addresses takes exactly `TEXT_CHARS` blank-high cycles.
- `busy` is combinational from state and `level`. All other outputs are registered.

## Configuration
- `TEXT_RAM_WRITER_CLEAR_EN`
  - Defined: the CLEAR state, the address counter and `clear_req` handling are compiled in.
  - Undefined: the `clear_req` port remains but is ignored, the FSM has only IDLE and DRAIN, and `CLEAR_CHAR` is unused.

## Structure
- Package `text_pkg`: the FSM state enum, the FIFO entry struct {addr, data}, and the default `CLEAR_CHAR` and `BASE_ADDR` constants shared with the VGA block.
- Sub-module `sync_fifo` (parameterised width/depth, single clock, async active-low reset). It provides `full`, `empty` and `level`, supports push and pop in the same cycle, and has no read latency beyond registered outputs.

## Test plan
- Store `data_adr`=32'h1005, `write_data`=32'h41 with `blank`=1 → `ram_wren`=1 with `ram_addr`=5, `ram_data`=8'h41 two edges later.
- 9 hits with `blank`=0 and `DEPTH`=8 → `level`=8 and `overflow`=1. Raise `blank` → exactly 8 writes appear in order, then `busy`=0.
- Stores to 32'h0FFF and 32'h2000 → no push and `level` stays 0.
- 4 queued writes, `blank` dropped after the 2nd pop → 2 writes, a pause, then the remaining 2 on the next blank.
- `clear_req` with `TEXT_RAM_WRITER_CLEAR_EN` defined and `TEXT_CHARS`=16, with a store at 32'h1003 mid-clear → 16 writes of 8'h20 to addresses 0..15, then address 3 gets the stored byte.
- Assert `reset` low during DRAIN with 5 queued entries → `ram_wren`=0 and `level`=0 immediately. After release there are no further writes.

Source files
------------

// File: rtl/text_pkg.sv
// text_pkg
//   Types and constants shared by the text RAM writer and the VGA text block.
//   - TEXT_BASE_ADDR  : default processor byte address of the text window
//   - TEXT_CLEAR_CHAR : default fill byte for the clear engine (ASCII space)
//   - ST_IDLE/ST_DRAIN/ST_CLEAR : writer FSM state encodings
//   - text_entry_t    : one buffered store {addr, data}; addr is sized for the
//                       widest supported RAM (ADDR_W <= TEXT_MAX_ADDR_W)
package text_pkg;

    localparam logic [31:0] TEXT_BASE_ADDR  = 32'h0000_1000;
    localparam logic [7:0]  TEXT_CLEAR_CHAR = 8'h20;
    localparam int          TEXT_MAX_ADDR_W = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DRAIN = 2'd1;
    localparam state_t ST_CLEAR = 2'd2;

    typedef struct packed {
        logic [TEXT_MAX_ADDR_W-1:0] addr;
        logic [7:0]                 data;
    } text_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with show-ahead read data (pop_data is the head entry
//   whenever empty is low).
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     push, push_data      : write request and data
//     pop                  : consume the head entry
//     pop_data             : head entry (valid while !empty)
//     full, empty, level   : occupancy status
//   Handshake: a push is taken when push && (!full || pop); a pop is taken
//   when pop && !empty. Push and pop in the same cycle are both taken, so a
//   full FIFO can accept a new entry while its head is consumed.
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    // When full, wr_ptr == rd_ptr; the head is read combinationally before
    // the edge that overwrites it, so push+pop on a full FIFO is safe.
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/text_ram_writer.sv
// text_ram_writer
//   Captures processor byte stores that hit the text window, buffers them in a
//   FIFO and writes them into the text RAM only while the display is blanked.
//   Optional clear engine (macro TEXT_RAM_WRITER_CLEAR_EN) fills the whole RAM
//   with CLEAR_CHAR on a clear_req pulse, again only during blanking.
//   Ports:
//     clk, reset              : clock, asynchronous active-low reset
//     mem_write, data_adr,
//     write_data              : processor store bus (only write_data[7:0] used)
//     blank                   : display outside visible area
//     clear_req               : one-cycle clear request (ignored without macro)
//     ram_addr, ram_data,
//     ram_wren                : registered RAM write port
//     busy                    : FIFO non-empty or FSM not idle
//     overflow                : sticky, a store was dropped on a full FIFO
//     level                   : FIFO occupancy
//     state_dbg               : current FSM state
module text_ram_writer
    import text_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = TEXT_BASE_ADDR,
    parameter int          TEXT_CHARS = 4096,
    parameter int          ADDR_W     = 12,
    parameter int          DEPTH      = 8,
    parameter logic [7:0]  CLEAR_CHAR = TEXT_CLEAR_CHAR,
    localparam int         LW         = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_write,
    input  logic [31:0]       data_adr,
    input  logic [31:0]       write_data,
    input  logic              blank,
    input  logic              clear_req,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              overflow,
    output logic [LW-1:0]     level,
    output state_t            state_dbg
);

    state_t      state;
    state_t      state_nxt;
    logic        hit;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] offset_full;
    text_entry_t push_entry;
    text_entry_t head;

    // 33-bit compare so a window ending at the top of the address map
    // cannot wrap.
    logic [32:0] adr_ext;
    logic [32:0] win_lo;
    logic [32:0] win_hi;

    assign adr_ext     = {1'b0, data_adr};
    assign win_lo      = {1'b0, BASE_ADDR};
    assign win_hi      = win_lo + 33'(TEXT_CHARS);
    assign hit         = mem_write && (adr_ext >= win_lo) && (adr_ext < win_hi);
    assign offset_full = data_adr - BASE_ADDR;

    always_comb begin
        push_entry                   = '0;
        push_entry.addr[ADDR_W-1:0]  = offset_full[ADDR_W-1:0];
        push_entry.data              = write_data[7:0];
    end

    sync_fifo #(
        .WIDTH ($bits(text_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (hit),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

`ifdef TEXT_RAM_WRITER_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_wr;
`endif

    // IDLE pops on the same edge it leaves for DRAIN, so a store can reach
    // the RAM port one edge after it lands in the FIFO.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
`ifdef TEXT_RAM_WRITER_CLEAR_EN
        clr_wr    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (blank && !fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_DRAIN;
                end
`ifdef TEXT_RAM_WRITER_CLEAR_EN
                // A clear request wins over draining in the same cycle.
                if (clear_req) begin
                    pop       = 1'b0;
                    state_nxt = ST_CLEAR;
                end
`endif
            end
            ST_DRAIN: begin
                if (blank && !fifo_empty) begin
                    pop = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
`ifdef TEXT_RAM_WRITER_CLEAR_EN
            ST_CLEAR: begin
                if (blank) begin
                    clr_wr = 1'b1;
                    if (clr_addr == ADDR_W'(TEXT_CHARS - 1)) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            ram_addr <= '0;
            ram_data <= '0;
            ram_wren <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
`ifdef TEXT_RAM_WRITER_CLEAR_EN
            ram_wren <= pop || clr_wr;
`else
            ram_wren <= pop;
`endif
            if (pop) begin
                ram_addr <= head.addr[ADDR_W-1:0];
                ram_data <= head.data;
            end
`ifdef TEXT_RAM_WRITER_CLEAR_EN
            else if (clr_wr) begin
                ram_addr <= clr_addr;
                ram_data <= CLEAR_CHAR;
            end
`endif
            if (hit && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef TEXT_RAM_WRITER_CLEAR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_addr <= '0;
        end else if (state == ST_IDLE && state_nxt == ST_CLEAR) begin
            clr_addr <= '0;
        end else if (clr_wr) begin
            clr_addr <= clr_addr + ADDR_W'(1);
        end
    end
`endif

    assign busy      = (state != ST_IDLE) || (level != '0);
    assign state_dbg = state;

    // Bits that are intentionally not consumed (upper data byte lanes, high
    // offset bits, and the clear inputs when the engine is compiled out).
    logic unused_ok;
    assign unused_ok = &{1'b0, write_data[31:8], head.addr, offset_full
`ifndef TEXT_RAM_WRITER_CLEAR_EN
                         , clear_req, CLEAR_CHAR
`endif
                        };

endmodule
